// File: rtl/buzz_arbiter.sv
// Four-player buzzer arbiter: first eligible press in an armed window wins, ties broken round-robin.
// Optional FALSE_START_EN macro adds per-player lockout for presses made before the window opens.
module buzz_arbiter #(
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int W              = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           arm,
    input  logic           ack,
    input  logic [3:0]     btn,
    input  logic [4*W-1:0] sw,
    output logic           busy,
    output logic           valid,
    output logic [1:0]     winner,
    output logic [W-1:0]   answer,
    output logic           timeout,
    output logic [3:0]     lockout
);

    // state   | meaning
    // IDLE    | waiting for arm; no window open
    // ARMED   | answer window running, watching for presses
    // HOLD    | winner/answer captured, waiting for ack
    // TOUT    | window expired with no eligible press, waiting for ack

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, HOLD, TOUT} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    rr_ptr;
    logic [3:0]    btn_q;
    logic [3:0]    press;
    logic [3:0]    eligible;
    logic          pick_found;
    logic [1:0]    pick;
    logic [1:0]    idx;
    logic [W-1:0]  sw_sel;

    assign press    = btn & ~btn_q;
    assign eligible = press & ~lockout;
    assign sw_sel   = sw[W*int'(pick) +: W];

    // Scan from rr_ptr upward, wrapping at 4; first eligible presser wins.
    always_comb begin
        pick_found = 1'b0;
        pick       = rr_ptr;
        idx        = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!pick_found && eligible[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

`ifdef FALSE_START_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lockout <= 4'b0000;
        end else if (state == IDLE) begin
            lockout <= lockout | press;
        end else if ((state == HOLD || state == TOUT) && ack) begin
            lockout <= 4'b0000;
        end
    end
`else
    assign lockout = 4'b0000;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            rr_ptr  <= 2'd0;
            btn_q   <= 4'b0000;
            busy    <= 1'b0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            winner  <= 2'd0;
            answer  <= '0;
        end else begin
            btn_q <= btn;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    // A press on the expiry cycle still wins over timeout.
                    if (pick_found) begin
                        state  <= HOLD;
                        winner <= pick;
                        answer <= sw_sel;
                        valid  <= 1'b1;
                    end else if (arm) begin
                        count <= '0;
                    end else if (count == LAST) begin
                        state   <= TOUT;
                        timeout <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                HOLD: begin
                    if (ack) begin
                        state  <= IDLE;
                        valid  <= 1'b0;
                        busy   <= 1'b0;
                        rr_ptr <= winner + 2'd1;
                    end
                end
                TOUT: begin
                    if (ack) begin
                        state   <= IDLE;
                        timeout <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    valid   <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buzz_arbiter.sv
// Self-checking bench for buzz_arbiter: vector table, directed corner sequences,
// and randomized traffic compared against a cycle-level behavioural model.
module tb_buzz_arbiter;

    localparam int TC = 100;
    localparam int W  = 8;
`ifdef FALSE_START_EN
    localparam bit FS = 1'b1;
`else
    localparam bit FS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, arm, ack;
    logic [3:0]  btn;
    logic [31:0] sw;
    logic        busy, valid, timeout;
    logic [1:0]  winner;
    logic [7:0]  answer;
    logic [3:0]  lockout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    buzz_arbiter #(.TIMEOUT_CYCLES(TC), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .ack(ack), .btn(btn), .sw(sw),
        .busy(busy), .valid(valid), .winner(winner), .answer(answer),
        .timeout(timeout), .lockout(lockout)
    );

    typedef struct {
        logic        rst_n, arm, ack;
        logic [3:0]  btn;
        logic [31:0] sw;
        logic        busy, valid;
        logic [1:0]  winner;
        logic [7:0]  answer;
        logic        tmo;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic a, input logic k,
                         input logic [3:0] b, input logic [31:0] s);
        rst_n = r; arm = a; ack = k; btn = b; sw = s;
    endtask

    function automatic logic [16:0] dut_outs();
        return {busy, valid, winner, answer, timeout, lockout};
    endfunction

    // Behavioural model: phase 0 idle, 1 armed, 2 hold, 3 timed out.
    int          m_mode = 0;
    int          m_cyc = 0;
    int          m_deadline = 0;
    logic [1:0]  m_rr = 2'd0;
    logic [1:0]  m_win = 2'd0;
    logic [7:0]  m_ans = 8'd0;
    logic [3:0]  m_prev = 4'd0;
    logic [3:0]  m_lock = 4'd0;

    function automatic void m_step(input logic rs, input logic a, input logic k,
                                   input logic [3:0] b, input logic [31:0] s);
        logic [3:0] pr;
        logic [3:0] el;
        int p;
        pr = b & ~m_prev;
        if (!rs) begin
            m_mode = 0; m_rr = 2'd0; m_win = 2'd0; m_ans = 8'd0;
            m_prev = 4'd0; m_lock = 4'd0;
        end else begin
            case (m_mode)
                0: begin
                    if (FS) m_lock = m_lock | pr;
                    if (a) begin m_mode = 1; m_deadline = m_cyc + TC; end
                end
                1: begin
                    el = pr & ~m_lock;
                    p = -1;
                    for (int j = 0; j < 4; j++)
                        if (p < 0 && el[(int'(m_rr) + j) % 4]) p = (int'(m_rr) + j) % 4;
                    if (p >= 0) begin
                        m_mode = 2; m_win = p[1:0]; m_ans = s[p*8 +: 8];
                    end else if (a) begin
                        m_deadline = m_cyc + TC;
                    end else if (m_cyc == m_deadline) begin
                        m_mode = 3;
                    end
                end
                2: if (k) begin m_rr = m_win + 2'd1; m_lock = 4'd0; m_mode = 0; end
                default: if (k) begin m_lock = 4'd0; m_mode = 0; end
            endcase
            m_prev = b;
        end
        m_cyc++;
    endfunction

    function automatic logic [16:0] m_outs();
        return {m_mode != 0, m_mode == 2, m_win, m_ans, m_mode == 3, m_lock};
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] nb;
        bit quiet;
        drive(1'b0, 1'b0, 1'b0, 4'b0, 32'h0);
        step();

        //           rst  arm  ack  btn      sw            busy valid win answer tmo
        vt.push_back('{1'b0,1'b0,1'b0,4'b0000,32'h00000000, 1'b0,1'b0,2'd0,8'h00,1'b0});
        vt.push_back('{1'b1,1'b0,1'b0,4'b0000,32'h00000000, 1'b0,1'b0,2'd0,8'h00,1'b0});
        vt.push_back('{1'b1,1'b1,1'b0,4'b0000,32'h00000000, 1'b1,1'b0,2'd0,8'h00,1'b0});
        vt.push_back('{1'b1,1'b0,1'b0,4'b0100,32'h005A0000, 1'b1,1'b1,2'd2,8'h5A,1'b0});
        vt.push_back('{1'b1,1'b0,1'b0,4'b0000,32'hFFFFFFFF, 1'b1,1'b1,2'd2,8'h5A,1'b0});
        vt.push_back('{1'b1,1'b1,1'b0,4'b0000,32'hFFFFFFFF, 1'b1,1'b1,2'd2,8'h5A,1'b0});
        vt.push_back('{1'b1,1'b0,1'b1,4'b0000,32'h00000000, 1'b0,1'b0,2'd2,8'h5A,1'b0});
        vt.push_back('{1'b1,1'b0,1'b1,4'b0000,32'h00000000, 1'b0,1'b0,2'd2,8'h5A,1'b0});
        vt.push_back('{1'b1,1'b1,1'b0,4'b0000,32'h00000000, 1'b1,1'b0,2'd2,8'h5A,1'b0});
        vt.push_back('{1'b1,1'b0,1'b0,4'b1010,32'h33001100, 1'b1,1'b1,2'd3,8'h33,1'b0});
        vt.push_back('{1'b1,1'b0,1'b1,4'b0000,32'h00000000, 1'b0,1'b0,2'd3,8'h33,1'b0});
        vt.push_back('{1'b1,1'b1,1'b0,4'b0000,32'h00000000, 1'b1,1'b0,2'd3,8'h33,1'b0});
        vt.push_back('{1'b1,1'b0,1'b0,4'b1010,32'h33001100, 1'b1,1'b1,2'd1,8'h11,1'b0});
        vt.push_back('{1'b1,1'b0,1'b1,4'b0000,32'h00000000, 1'b0,1'b0,2'd1,8'h11,1'b0});
        vt.push_back('{1'b1,1'b1,1'b0,4'b0000,32'h00000000, 1'b1,1'b0,2'd1,8'h11,1'b0});
        vt.push_back('{1'b1,1'b0,1'b0,4'b0001,32'h00000077, 1'b1,1'b1,2'd0,8'h77,1'b0});
        vt.push_back('{1'b0,1'b1,1'b1,4'b0000,32'h00000000, 1'b0,1'b0,2'd0,8'h00,1'b0});
        vt.push_back('{1'b1,1'b0,1'b0,4'b0000,32'h00000000, 1'b0,1'b0,2'd0,8'h00,1'b0});

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst_n, vt[i].arm, vt[i].ack, vt[i].btn, vt[i].sw);
            step();
            chk($sformatf("vec%0d", i), dut_outs(),
                {vt[i].busy, vt[i].valid, vt[i].winner, vt[i].answer, vt[i].tmo, 4'b0000});
        end

        // Timeout latency from the arm edge.
        drive(1'b1, 1'b1, 1'b0, 4'b0, 32'h0); step();
        arm = 1'b0; n = 0;
        while (!timeout && n < 200) begin step(); n++; end
        chk("timeout_latency", 64'(n), 64'(TC));
        chk("timeout_flags", {busy, valid}, 2'b10);
        ack = 1'b1; step(); ack = 1'b0;
        chk("timeout_ack", {busy, valid, timeout}, 3'b000);

        // Re-arm mid-window restarts the count.
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 50; i++) step();
        arm = 1'b1; step(); arm = 1'b0; n = 0;
        while (!timeout && n < 200) begin step(); n++; end
        chk("rearm_latency", 64'(n), 64'(TC));
        ack = 1'b1; step(); ack = 1'b0;

        // Press landing on the expiry cycle wins.
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < TC - 1; i++) step();
        chk("pre_expiry", {valid, timeout}, 2'b00);
        btn = 4'b0100; sw = 32'h00A50000; step(); btn = 4'b0000;
        chk("expiry_press", {valid, timeout, winner, answer}, {1'b1, 1'b0, 2'd2, 8'hA5});
        ack = 1'b1; step(); ack = 1'b0;

        // Button held through arm must not count.
        btn = 4'b0001; step();
        arm = 1'b1; step(); arm = 1'b0;
        step(); step(); step();
        chk("held_no_win", valid, 1'b0);
        btn = 4'b0000; step();
        btn = 4'b0001; sw = 32'h000000C3; step();
        if (FS) chk("held_locked", {valid, lockout}, {1'b0, 4'b0001});
        else    chk("held_repress", {valid, winner, answer}, {1'b1, 2'd0, 8'hC3});
        rst_n = 1'b0; btn = 4'b0000; step(); rst_n = 1'b1; step();

        // False start in idle.
        btn = 4'b0010; step(); btn = 4'b0000; step();
        chk("fs_lockout", lockout, FS ? 4'b0010 : 4'b0000);
        arm = 1'b1; step(); arm = 1'b0;
        btn = 4'b0010; sw = 32'h00002200; step(); btn = 4'b0000;
        if (FS) chk("fs_ignored", valid, 1'b0);
        else    chk("fs_nolock_win", {valid, winner, answer}, {1'b1, 2'd1, 8'h22});
        step();
        btn = 4'b0001; sw = 32'h00000011; step(); btn = 4'b0000;
        chk("fs_winner", {valid, winner}, FS ? {1'b1, 2'd0} : {1'b1, 2'd1});
        ack = 1'b1; step(); ack = 1'b0;
        chk("fs_clear", {valid, lockout}, {1'b0, 4'b0000});

        // Randomized traffic against the model.
        nb = 4'b0000;
        for (int c = 0; c < 4000; c++) begin
            quiet = ((c / 300) % 3) == 2;
            if (!quiet)
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(7) == 0) nb[b] = ~nb[b];
            drive((c == 0) ? 1'b0 : ($urandom_range(499) != 0),
                  $urandom_range(19) == 0, $urandom_range(9) == 0, nb, $urandom);
            m_step(rst_n, arm, ack, btn, sw);
            step();
            chk("random", dut_outs(), m_outs());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
